interrupt_flag_ctrl: RTL

Interrupt sequencer sitting between the external interrupt pin and the control unit. It drives the flag shadow/restore strobes into the flag-register stage.
- Synchronises and edge-latches the external request.
- Owns the interrupt-enable flag (I).
- Tells the control unit when to vector.
- On vectoring, pulses the shadow-load strobe; on return, drives the restore select/load.
- Enforces a post-return hold-off so at least one instruction runs before re-entry.

---
 rtl/interrupt_flag_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/interrupt_flag_ctrl.sv
// interrupt_flag_ctrl: interrupt sequencer between the external INTR_IN pin
// and the control unit. It synchronises and edge-latches the request, owns the
// interrupt-enable flag I, and strobes the C/Z flag shadow on entry and the
// restore on return. A post-return hold-off guarantees at least one
// instruction runs before the next entry.
// Optional build macro: INT_DROP_COUNT_EN adds the DROP_CNT lost-interrupt
// counter output.
module interrupt_flag_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int HOLDOFF_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       INTR_IN,
  input  logic       INT_SET,
  input  logic       INT_CLR,
  input  logic       INT_ACK,
  input  logic       RETI,
  input  logic       RETI_IE,
  output logic       INT_PEND,
  output logic       I_FLAG,
  output logic       FLG_SHAD_LD,
  output logic       FLG_LD_SEL,
  output logic       FLG_RESTORE
`ifdef INT_DROP_COUNT_EN
  ,
  output logic [7:0] DROP_CNT
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVICE = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_last_d_q, sync_last_d_d;
  logic                   pend_latch_q, pend_latch_d;
  logic                   i_flag_q, i_flag_d;
  logic [3:0]             hold_cnt_q, hold_cnt_d;

  logic                   sync_last;
  logic                   intr_edge;
  logic                   int_pend;
  logic                   ack_accept;
  logic                   reti_accept;

`ifdef INT_DROP_COUNT_EN
  logic [7:0]             drop_cnt_q, drop_cnt_d;
`endif

  // Synchroniser shift, edge detection and the sticky pending latch.
  always_comb begin
    sync_d        = {sync_q[SYNC_STAGES-2:0], INTR_IN};
    sync_last     = sync_q[SYNC_STAGES-1];
    sync_last_d_d = sync_last;
    intr_edge     = sync_last & ~sync_last_d_q;

    int_pend    = pend_latch_q & i_flag_q & (state_q == IDLE);
    ack_accept  = INT_ACK & int_pend;
    reti_accept = RETI & (state_q == SERVICE);

    // A fresh edge on the accept cycle must survive the clear.
    pend_latch_d = pend_latch_q;
    if (intr_edge) begin
      pend_latch_d = 1'b1;
    end else if (ack_accept) begin
      pend_latch_d = 1'b0;
    end
  end

  // Interrupt-enable flag: entry clears it, CLI beats SEI, return restores it.
  always_comb begin
    i_flag_d = i_flag_q;
    if (ack_accept) begin
      i_flag_d = 1'b0;
    end else if (INT_CLR) begin
      i_flag_d = 1'b0;
    end else if (INT_SET) begin
      i_flag_d = 1'b1;
    end else if (reti_accept) begin
      i_flag_d = RETI_IE;
    end
  end

  // Sequencer next state, hold-off counter and zero-latency flag-stage strobes.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    FLG_SHAD_LD = 1'b0;
    FLG_LD_SEL  = 1'b0;
    FLG_RESTORE = 1'b0;

    case (state_q)
      IDLE: begin
        if (ack_accept) begin
          FLG_SHAD_LD = 1'b1;
          state_d     = SERVICE;
        end
      end
      SERVICE: begin
        if (reti_accept) begin
          FLG_LD_SEL  = 1'b1;
          FLG_RESTORE = 1'b1;
          hold_cnt_d  = 4'(HOLDOFF_CYCLES);
          state_d     = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (hold_cnt_q <= 4'd1) begin
          hold_cnt_d = 4'd0;
          state_d    = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d    = IDLE;
        hold_cnt_d = 4'd0;
      end
    endcase
  end

`ifdef INT_DROP_COUNT_EN
  // Lost-interrupt counter: an edge that lands on an already pending,
  // not-being-cleared latch is a dropped request. CLI clears the count.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (INT_CLR) begin
      drop_cnt_d = 8'd0;
    end else if (intr_edge && pend_latch_q && !ack_accept && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Lost-interrupt counter register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign DROP_CNT = drop_cnt_q;
`endif

  // State registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q        <= '0;
      sync_last_d_q <= 1'b0;
      pend_latch_q  <= 1'b0;
      i_flag_q      <= 1'b0;
      state_q       <= IDLE;
      hold_cnt_q    <= 4'd0;
    end else begin
      sync_q        <= sync_d;
      sync_last_d_q <= sync_last_d_d;
      pend_latch_q  <= pend_latch_d;
      i_flag_q      <= i_flag_d;
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  assign INT_PEND = int_pend;
  assign I_FLAG   = i_flag_q;

endmodule
